// File: rtl/mul_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
//   mul_state_e : 2-bit sequencer state encoding
//   hilo_sel_e  : read-port HI/LO select
//   hilo_t      : 64-bit product split into HI and LO halves
package mul_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned PROD_W          = 2 * DATA_W;
  localparam int unsigned MUL_LATENCY_DEF = 10;
  localparam int unsigned CNT_W_DEF       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } mul_state_e;

  typedef enum logic {
    SEL_LO = 1'b0,
    SEL_HI = 1'b1
  } hilo_sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // HI wins when both reads are requested.
  function automatic hilo_sel_e rd_sel(input logic rd_hi);
    return rd_hi ? SEL_HI : SEL_LO;
  endfunction

endpackage

// File: rtl/hilo_regfile.sv
// HI/LO register pair: move writes, product capture, read mux with write bypass.
//   clk, rst_n : clock, async active-low reset (clears HI/LO)
//   wr_hi/lo   : move-to-HI/LO enables (already qualified by the sequencer)
//   wr_data    : move data
//   cap_en     : load {HI,LO} from product this cycle
//   product    : multiplier result
//   rd_hi/lo   : read requests
//   rd_data    : combinational read data, 0 when no read requested
module hilo_regfile
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cap_en,
  input  hilo_t             product,
  input  logic              rd_hi,
  input  logic              rd_lo,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  hilo_sel_e         sel;

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Capture has priority; moves are never enabled while a product is in flight anyway.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (cap_en) begin
      hi_d = product.hi;
      lo_d = product.lo;
    end else begin
      if (wr_hi) hi_d = wr_data;
      if (wr_lo) lo_d = wr_data;
    end
  end

  // Read mux; a same-cycle move to the selected register is forwarded.
  always_comb begin
    rd_data = '0;
    sel     = rd_sel(rd_hi);
    if (rd_hi || rd_lo) begin
      if (sel == SEL_HI) rd_data = wr_hi ? wr_data : hi_q;
      else               rd_data = wr_lo ? wr_data : lo_q;
    end
  end

endmodule

// File: rtl/mul_hilo_sequencer.sv
// Issue/retire sequencer around a fixed-latency signed 32x32 multiplier.
//   Clk, Reset        : clock, async active-low reset
//   Start, Op_A, Op_B : MULT issue and operands (sampled when accepted in IDLE)
//   Mthi, Mtlo, Wr_Data : moves to HI/LO
//   Mfhi, Mflo        : reads from HI/LO on Rd_Data (combinational)
//   Mul_Product       : product from the multiplier
//   Mul_A, Mul_B      : held operands to the multiplier
//   Mul_Clear         : one-cycle clear pulse to the multiplier (LAUNCH)
//   Busy              : product in flight (LAUNCH/RUN/CAPTURE)
//   Stall             : any request arriving while Busy (combinational)
//   Done              : pulse in the cycle HI/LO take the product
module mul_hilo_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF   // 2**CNT_W must exceed MUL_LATENCY
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Op_A,
  input  logic [DATA_W-1:0] Op_B,
  input  logic              Mthi,
  input  logic              Mtlo,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic              Mfhi,
  input  logic              Mflo,
  input  logic [PROD_W-1:0] Mul_Product,
  output logic [DATA_W-1:0] Mul_A,
  output logic [DATA_W-1:0] Mul_B,
  output logic              Mul_Clear,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Busy,
  output logic              Stall,
  output logic              Done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic              busy_q, busy_d;
  logic              clear_q, clear_d;
  logic              done_q, done_d;

  logic              idle;
  logic              start_acc;
  logic              any_req;

  assign idle      = (state_q == ST_IDLE);
  assign start_acc = idle & Start;
  assign any_req   = Start | Mfhi | Mflo | Mthi | Mtlo;

  // State, counter and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
      done_q  <= done_d;
    end
  end

  // Next state and latency counter; the counter sits at 0 outside RUN.
  always_comb begin
    state_d = state_q;
    count_d = '0;
    unique case (state_q)
      ST_IDLE:    if (Start) state_d = ST_LAUNCH;
      ST_LAUNCH:  state_d = ST_RUN;
      ST_RUN: begin
        if (count_q == CNT_LAST) state_d = ST_CAPTURE;
        else                     count_d = count_q + CNT_W'(1);
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they come straight from flops.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    clear_d = (state_d == ST_LAUNCH);
    done_d  = (state_d == ST_CAPTURE);
    mul_a_d = start_acc ? Op_A : mul_a_q;
    mul_b_d = start_acc ? Op_B : mul_b_q;
  end

  assign Mul_A     = mul_a_q;
  assign Mul_B     = mul_b_q;
  assign Mul_Clear = clear_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Stall     = busy_q & any_req;

  // Moves only take effect in IDLE; stalled moves leave HI/LO untouched.
  hilo_regfile u_hilo (
    .clk     (Clk),
    .rst_n   (Reset),
    .wr_hi   (idle & Mthi),
    .wr_lo   (idle & Mtlo),
    .wr_data (Wr_Data),
    .cap_en  (state_q == ST_CAPTURE),
    .product (Mul_Product),
    .rd_hi   (Mfhi),
    .rd_lo   (Mflo),
    .rd_data (Rd_Data)
  );

endmodule
